// File: rtl/seg_scan_display.sv
// Multiplexed common-anode 7-segment scanner with frame-coherent shadow capture, dp, blink and LZ blanking.
// Optional macro SEG_SCAN_DIM_EN adds a 3-bit per-frame brightness (PWM within each digit slot).
module seg_scan_display #(
  parameter int NUM_DIGITS  = 6,
  parameter int SCAN_DIV    = 200000,
  parameter int BLINK_TICKS = 125,
  parameter int HEX_EN      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lz_en,
`ifdef SEG_SCAN_DIM_EN
  input  logic [2:0]              bright,
`endif
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   seg_en
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    g = 7'b1111111;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: if (HEX_EN != 0) g = 7'b0001000;
      4'hB: if (HEX_EN != 0) g = 7'b0000011;
      4'hC: if (HEX_EN != 0) g = 7'b1000110;
      4'hD: if (HEX_EN != 0) g = 7'b0100001;
      4'hE: if (HEX_EN != 0) g = 7'b0000110;
      4'hF: if (HEX_EN != 0) g = 7'b0001110;
      default: ;
    endcase
    return g;
  endfunction

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [BLK_W-1:0]        blink_cnt;
  logic                    blink_phase;
  logic                    load_pending;

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic                    sh_lz;
`ifdef SEG_SCAN_DIM_EN
  logic [2:0]              sh_bright;
`endif

  logic                    tick;
  logic                    idx_last;
  logic                    frame_start;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_val;
  logic                    dim_off;
  logic                    blanked;
  logic [NUM_DIGITS-1:0]   en_onehot;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    logic all_zero;
    tick        = (div_cnt == DIV_LAST);
    idx_last    = (idx == IDX_LAST);
    frame_start = (tick && idx_last) || load_pending;
    cur_val     = sh_digits[{idx, 2'b00} +: 4];
    en_onehot   = NUM_DIGITS'(1) << idx;
    lz_blank    = '0;
    all_zero    = 1'b1;
    // A digit is suppressed only if it and every more significant digit are zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero    = all_zero && (sh_digits[4*i +: 4] == 4'h0);
      lz_blank[i] = sh_lz && all_zero && (i != 0);
    end
`ifdef SEG_SCAN_DIM_EN
    begin
      logic [DIV_W+3:0] dim_prod;
      dim_prod = (DIV_W+4)'({1'b0, sh_bright} + 4'd1) * (DIV_W+4)'(SCAN_DIV);
      dim_off  = !((DIV_W+4)'(div_cnt) < (dim_prod >> 3));
    end
`else
    dim_off = 1'b0;
`endif
    // Shadows are not yet valid while load_pending, so keep the tubes dark.
    blanked = load_pending || (blink_phase && sh_blink[idx]) || lz_blank[idx] || dim_off;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      idx          <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      load_pending <= 1'b1;
      sh_digits    <= '0;
      sh_dp        <= '0;
      sh_blink     <= '0;
      sh_lz        <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
      sh_bright    <= '0;
`endif
      seg_out      <= 8'hFF;
      seg_en       <= '1;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);

      if (tick) begin
        idx <= idx_last ? '0 : idx + IDX_W'(1);
        if (blink_cnt == BLK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end

      if (frame_start) begin
        sh_digits    <= digits;
        sh_dp        <= dp;
        sh_blink     <= blink;
        sh_lz        <= lz_en;
`ifdef SEG_SCAN_DIM_EN
        sh_bright    <= bright;
`endif
        load_pending <= 1'b0;
      end

      if (blanked) begin
        seg_out <= 8'hFF;
        seg_en  <= '1;
      end else begin
        seg_out <= {~sh_dp[idx], glyph(cur_val)};
        seg_en  <= ~en_onehot;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: 4-digit base, 4-digit hex and 3-digit instances share one stimulus bus.
module tb_seg_scan_display;

  logic        clk;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blink;
  logic        lz_en;
`ifdef SEG_SCAN_DIM_EN
  logic [2:0]  bright;
`endif

  logic [7:0]  so_a, so_h, so_3;
  logic [3:0]  en_a, en_h;
  logic [2:0]  en_3;

  int cyc;
  int checks;
  int failures;

  seg_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_TICKS(2), .HEX_EN(0)) u_dut (
    .clk(clk), .rst(rst), .digits(digits), .dp(dp), .blink(blink), .lz_en(lz_en),
`ifdef SEG_SCAN_DIM_EN
    .bright(bright),
`endif
    .seg_out(so_a), .seg_en(en_a)
  );

  seg_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_TICKS(2), .HEX_EN(1)) u_hex (
    .clk(clk), .rst(rst), .digits(digits), .dp(dp), .blink(blink), .lz_en(lz_en),
`ifdef SEG_SCAN_DIM_EN
    .bright(bright),
`endif
    .seg_out(so_h), .seg_en(en_h)
  );

  seg_scan_display #(.NUM_DIGITS(3), .SCAN_DIV(4), .BLINK_TICKS(2), .HEX_EN(0)) u_d3 (
    .clk(clk), .rst(rst), .digits(digits[11:0]), .dp(dp[2:0]), .blink(blink[2:0]), .lz_en(lz_en),
`ifdef SEG_SCAN_DIM_EN
    .bright(bright),
`endif
    .seg_out(so_3), .seg_en(en_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = number of clock edges since rst was last sampled high.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic test_reset();
    digits = 16'h1234; dp = 4'b0000; blink = 4'b0000; lz_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (en_a !== 4'b1111) begin failures++; $display("FAIL reset_en_a got=%b exp=1111", en_a); end
    checks++; if (so_a !== 8'hFF)   begin failures++; $display("FAIL reset_so_a got=%h exp=ff", so_a); end
    checks++; if (en_h !== 4'b1111) begin failures++; $display("FAIL reset_en_h got=%b exp=1111", en_h); end
    checks++; if (en_3 !== 3'b111)  begin failures++; $display("FAIL reset_en_3 got=%b exp=111", en_3); end
    checks++; if (u_dut.idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", u_dut.idx); end
  endtask

  task automatic test_basic_scan();
    int         k_tab [8] = '{2, 4, 5, 6, 10, 14, 16, 17};
    logic [3:0] e_tab [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b0111, 4'b0111, 4'b1110};
    logic [7:0] s_tab [8] = '{8'h99, 8'h99, 8'hB0, 8'hB0, 8'hA4, 8'hF9, 8'hF9, 8'h99};
    digits = 16'h1234; dp = 4'b0000; blink = 4'b0000; lz_en = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wait_cyc(k_tab[i]);
      checks++;
      if (en_a !== e_tab[i] || so_a !== s_tab[i]) begin
        failures++;
        $display("FAIL basic_scan cyc=%0d got en=%b seg=%h exp en=%b seg=%h", cyc, en_a, so_a, e_tab[i], s_tab[i]);
      end
    end
  endtask

  task automatic test_leading_zero();
    digits = 16'h0005; dp = 4'b0000; blink = 4'b0000; lz_en = 1'b1;
    do_reset();
    wait_cyc(2);
    checks++; if (en_a !== 4'b1110 || so_a !== 8'h92) begin failures++; $display("FAIL lz_digit0 got en=%b seg=%h exp en=1110 seg=92", en_a, so_a); end
    for (int s = 1; s < 4; s++) begin
      wait_cyc(4*s + 2);
      checks++;
      if (en_a !== 4'b1111 || so_a !== 8'hFF) begin
        failures++; $display("FAIL lz_suppressed slot=%0d got en=%b seg=%h exp en=1111 seg=ff", s, en_a, so_a);
      end
    end
    digits = 16'h0000;
    wait_cyc(18);
    checks++; if (en_a !== 4'b1110 || so_a !== 8'hC0) begin failures++; $display("FAIL lz_all_zero_d0 got en=%b seg=%h exp en=1110 seg=c0", en_a, so_a); end
    wait_cyc(22);
    checks++; if (en_a !== 4'b1111 || so_a !== 8'hFF) begin failures++; $display("FAIL lz_all_zero_d1 got en=%b seg=%h exp en=1111 seg=ff", en_a, so_a); end
    lz_en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      logic [3:0] e;
      e = ~(4'b0001 << s);
      wait_cyc(34 + 4*s);
      checks++;
      if (en_a !== e || so_a !== 8'hC0) begin
        failures++; $display("FAIL lz_off slot=%0d got en=%b seg=%h exp en=%b seg=c0", s, en_a, so_a, e);
      end
    end
  endtask

  task automatic test_frame_coherence();
    int         k_tab [7] = '{22, 26, 30, 34, 38, 42, 46};
    logic [3:0] e_tab [7] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] s_tab [7] = '{8'hF9, 8'hF9, 8'hF9, 8'h90, 8'h90, 8'h90, 8'h90};
    digits = 16'h1111; dp = 4'b0000; blink = 4'b0000; lz_en = 1'b0;
    do_reset();
    wait_cyc(21);
    digits = 16'h9999;
    for (int i = 0; i < 7; i++) begin
      wait_cyc(k_tab[i]);
      checks++;
      if (en_a !== e_tab[i] || so_a !== s_tab[i]) begin
        failures++;
        $display("FAIL frame_coherence cyc=%0d got en=%b seg=%h exp en=%b seg=%h", cyc, en_a, so_a, e_tab[i], s_tab[i]);
      end
    end
  endtask

  task automatic test_blink_dp();
    digits = 16'h1234; dp = 4'b0100; blink = 4'b0001; lz_en = 1'b0;
    do_reset();
    wait_cyc(2);
    checks++; if (en_a !== 4'b1110 || so_a !== 8'h99) begin failures++; $display("FAIL blink_d0_on got en=%b seg=%h exp en=1110 seg=99", en_a, so_a); end
    checks++; if (en_3 !== 3'b110 || so_3 !== 8'h99) begin failures++; $display("FAIL blink3_j0 got en=%b seg=%h exp en=110 seg=99", en_3, so_3); end
    wait_cyc(6);
    checks++; if (en_a !== 4'b1101 || so_a !== 8'hB0) begin failures++; $display("FAIL dp_d1_off got en=%b seg=%h exp en=1101 seg=b0", en_a, so_a); end
    wait_cyc(10);
    checks++; if (en_a !== 4'b1011 || so_a !== 8'h24) begin failures++; $display("FAIL dp_d2_on got en=%b seg=%h exp en=1011 seg=24", en_a, so_a); end
    checks++; if (en_3 !== 3'b011 || so_3 !== 8'h24) begin failures++; $display("FAIL dp3_d2_on got en=%b seg=%h exp en=011 seg=24", en_3, so_3); end
    wait_cyc(14);
    checks++; if (en_a !== 4'b0111 || so_a !== 8'hF9) begin failures++; $display("FAIL dp_d3_off got en=%b seg=%h exp en=0111 seg=f9", en_a, so_a); end
    checks++; if (en_3 !== 3'b111 || so_3 !== 8'hFF) begin failures++; $display("FAIL blink3_j3_dark got en=%b seg=%h exp en=111 seg=ff", en_3, so_3); end
    wait_cyc(18);
    checks++; if (en_a !== 4'b1110 || so_a !== 8'h99) begin failures++; $display("FAIL blink_d0_f1 got en=%b seg=%h exp en=1110 seg=99", en_a, so_a); end
    wait_cyc(26);
    checks++; if (en_3 !== 3'b111 || so_3 !== 8'hFF) begin failures++; $display("FAIL blink3_j6_dark got en=%b seg=%h exp en=111 seg=ff", en_3, so_3); end
    wait_cyc(38);
    checks++; if (en_3 !== 3'b110 || so_3 !== 8'h99) begin failures++; $display("FAIL blink3_j9_on got en=%b seg=%h exp en=110 seg=99", en_3, so_3); end
    blink = 4'b0100;
    wait_cyc(50);
    checks++; if (en_a !== 4'b1110 || so_a !== 8'h99) begin failures++; $display("FAIL blink_d0_cleared got en=%b seg=%h exp en=1110 seg=99", en_a, so_a); end
    wait_cyc(54);
    checks++; if (en_a !== 4'b1101 || so_a !== 8'hB0) begin failures++; $display("FAIL blink_d1_on got en=%b seg=%h exp en=1101 seg=b0", en_a, so_a); end
    wait_cyc(58);
    checks++; if (en_a !== 4'b1111 || so_a !== 8'hFF) begin failures++; $display("FAIL blink_d2_dark_dp got en=%b seg=%h exp en=1111 seg=ff", en_a, so_a); end
  endtask

  task automatic test_hex();
    digits = 16'h00AF; dp = 4'b0000; blink = 4'b0000; lz_en = 1'b0;
    do_reset();
    wait_cyc(2);
    checks++; if (so_a !== 8'hFF) begin failures++; $display("FAIL hex_off_F got seg=%h exp seg=ff", so_a); end
    checks++; if (en_h !== 4'b1110 || so_h !== 8'h8E) begin failures++; $display("FAIL hex_on_F got en=%b seg=%h exp en=1110 seg=8e", en_h, so_h); end
    wait_cyc(6);
    checks++; if (so_a !== 8'hFF) begin failures++; $display("FAIL hex_off_A got seg=%h exp seg=ff", so_a); end
    checks++; if (en_h !== 4'b1101 || so_h !== 8'h88) begin failures++; $display("FAIL hex_on_A got en=%b seg=%h exp en=1101 seg=88", en_h, so_h); end
    wait_cyc(10);
    checks++; if (so_a !== 8'hC0 || so_h !== 8'hC0) begin failures++; $display("FAIL hex_zero got seg=%h/%h exp seg=c0/c0", so_a, so_h); end
  endtask

  task automatic test_reset_mid_scan();
    logic [2:0] e3_tab [4] = '{3'b110, 3'b101, 3'b011, 3'b110};
    int max_idx;
    digits = 16'h1234; dp = 4'b0000; blink = 4'b0000; lz_en = 1'b0;
    do_reset();
    wait_cyc(10);
    checks++; if (en_a !== 4'b1011) begin failures++; $display("FAIL midrst_pre got en=%b exp en=1011", en_a); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (en_a !== 4'b1111 || so_a !== 8'hFF) begin failures++; $display("FAIL midrst_dark got en=%b seg=%h exp en=1111 seg=ff", en_a, so_a); end
    checks++; if (u_dut.idx !== 2'd0) begin failures++; $display("FAIL midrst_idx got=%0d exp=0", u_dut.idx); end
    rst = 1'b0;
    wait_cyc(2);
    checks++; if (en_a !== 4'b1110 || so_a !== 8'h99) begin failures++; $display("FAIL midrst_resume got en=%b seg=%h exp en=1110 seg=99", en_a, so_a); end
    for (int j = 0; j < 4; j++) begin
      wait_cyc(4*j + 2);
      checks++;
      if (en_3 !== e3_tab[j]) begin
        failures++; $display("FAIL wrap3 slot=%0d got en=%b exp en=%b", j, en_3, e3_tab[j]);
      end
    end
    max_idx = 0;
    repeat (60) begin
      @(negedge clk);
      if (int'(u_d3.idx) > max_idx) max_idx = int'(u_d3.idx);
    end
    checks++; if (max_idx !== 2) begin failures++; $display("FAIL wrap3_max_idx got=%0d exp=2", max_idx); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    digits   = '0;
    dp       = '0;
    blink    = '0;
    lz_en    = 1'b0;
`ifdef SEG_SCAN_DIM_EN
    bright   = 3'd7;
`endif
    test_reset();
    test_basic_scan();
    test_leading_zero();
    test_frame_coherence();
    test_blink_dp();
    test_hex();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
